// File: rtl/pipelined_acc_alu.sv
// Two-stage pipelined ALU with valid/ready handshake, status flags and a result accumulator.
// Stage 1 holds the operand beat; stage 2 computes on the s1->s2 transfer and registers result/flags.
module pipelined_acc_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_cin;
  logic             s1_acc_sel;
  logic [WIDTH-1:0] acc;

  logic             s2_ready;
  logic             in_xfer;
  logic             s1_xfer;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign in_xfer  = in_valid && in_ready;
  assign s1_xfer  = s1_valid && s2_ready;
  assign op_a     = s1_acc_sel ? acc : s1_a;

  always_comb begin
    sum      = '0;
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (s1_op)
      3'b000: begin
        sum     = {1'b0, op_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
        alu_ovf = (op_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      3'b001: begin
        sum     = {1'b0, op_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, s1_cin};
        alu_ovf = (op_a[WIDTH-1] == ~s1_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      3'b010:  sum = {1'b0, op_a} + {{WIDTH{1'b0}}, 1'b1};
      3'b011:  sum = {1'b0, op_a} + {1'b0, {WIDTH{1'b1}}};
      3'b100:  alu_res = op_a & s1_b;
      3'b101:  alu_res = op_a | s1_b;
      3'b110:  alu_res = op_a ^ s1_b;
      default: alu_res = ~op_a;
    endcase
    // Arithmetic ops take result and carry from the extended sum; logic ops keep cout=0.
    if (!s1_op[2]) begin
      alu_res  = sum[WIDTH-1:0];
      alu_cout = sum[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_cin     <= 1'b0;
      s1_acc_sel <= 1'b0;
    end else if (in_xfer) begin
      s1_valid   <= 1'b1;
      s1_a       <= a;
      s1_b       <= b;
      s1_op      <= op;
      s1_cin     <= cin;
      s1_acc_sel <= acc_sel;
    end else if (s1_xfer) begin
      s1_valid   <= 1'b0;
    end
  end

  // The accumulator updates on the same edge the result is registered, so a following
  // acc_sel beat sitting in stage 1 sees it on the next cycle without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (s1_xfer) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      cout      <= alu_cout;
      zero      <= (alu_res == '0);
      neg       <= alu_res[WIDTH-1];
      ovf       <= alu_ovf;
      acc       <= alu_res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_acc_alu.sv
// Self-checking bench for pipelined_acc_alu (WIDTH=8): vector table, corner sequences,
// and a scoreboard fed by a reference model for random traffic with backpressure.
module tb_pipelined_acc_alu;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       n;
    logic       o;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       cin;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       cin, acc_sel;
  logic       out_valid, out_ready;
  logic [7:0] result;
  logic       cout, zero, neg, ovf;

  int         nVec = 0;
  int         nMis = 0;
  int         cyc = 0;
  int         lastAcceptCyc = 0;
  int         lastEmitCyc = 0;
  logic [7:0] modelAcc = '0;
  bit         accepted, emitted;
  exp_t       sb[$];
  int         emitCycs[$];
  vec_t       tab[14];

  pipelined_acc_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .acc_sel(acc_sel),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                 input logic [2:0] o, input logic c);
    exp_t e;
    int   s;
    int   ss;
    e  = '0;
    s  = 0;
    ss = 0;
    case (o)
      3'd0: begin
        s  = int'(av) + int'(bv) + int'(c);
        ss = int'($signed(av)) + int'($signed(bv)) + int'(c);
        e.o = (ss > 127) || (ss < -128);
      end
      3'd1: begin
        s  = int'(av) + (255 - int'(bv)) + int'(c);
        ss = int'($signed(av)) - int'($signed(bv)) - 1 + int'(c);
        e.o = (ss > 127) || (ss < -128);
      end
      3'd2: s = int'(av) + 1;
      3'd3: s = int'(av) + 255;
      3'd4: s = int'(av & bv);
      3'd5: s = int'(av | bv);
      3'd6: s = int'(av ^ bv);
      default: s = int'(~av);
    endcase
    e.res = s[7:0];
    e.c   = (o < 3'd4) && (s > 255);
    e.z   = (e.res == 8'h00);
    e.n   = e.res[7];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] req);
    nVec++;
    if (got !== req) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, then let the rising edge happen.
  task automatic applyStimulus(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                               input logic [2:0] iop, input bit icin, input bit iacc,
                               input bit ordy, input bit useTab, input exp_t te);
    exp_t m;
    exp_t got;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    cin       = icin;
    acc_sel   = iacc;
    out_ready = ordy;
    #1;
    accepted = rst_n && in_valid && in_ready;
    emitted  = out_valid && out_ready;
    if (emitted) begin
      lastEmitCyc = cyc;
      emitCycs.push_back(cyc);
      got = '{res: result, c: cout, z: zero, n: neg, o: ovf};
      if (sb.size() == 0) checkOutput("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
      else checkOutput("beat", 32'(got), 32'(sb.pop_front()));
    end
    if (accepted) begin
      lastAcceptCyc = cyc;
      m = model(iacc ? modelAcc : ia, ib, iop, icin);
      modelAcc = m.res;
      sb.push_back(useTab ? te : m);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, '0);
    checkOutput("drain_left", 32'(sb.size()), 0);
  endtask

  initial begin
    int nAcc;
    int emitSeen;
    rst_n = 1'b0; in_valid = 0; a = 0; b = 0; op = 0; cin = 0; acc_sel = 0; out_ready = 1;

    tab[0]  = '{8'hFF, 8'h01, 3'd0, 1'b0, '{8'h00, 1, 1, 0, 0}};
    tab[1]  = '{8'h80, 8'h01, 3'd1, 1'b1, '{8'h7F, 1, 0, 0, 1}};
    tab[2]  = '{8'h00, 8'h00, 3'd3, 1'b0, '{8'hFF, 0, 0, 1, 0}};
    tab[3]  = '{8'h7F, 8'h00, 3'd2, 1'b0, '{8'h80, 0, 0, 1, 0}};
    tab[4]  = '{8'hFF, 8'h00, 3'd2, 1'b0, '{8'h00, 1, 1, 0, 0}};
    tab[5]  = '{8'hF0, 8'h3C, 3'd4, 1'b1, '{8'h30, 0, 0, 0, 0}};
    tab[6]  = '{8'h0F, 8'h30, 3'd5, 1'b0, '{8'h3F, 0, 0, 0, 0}};
    tab[7]  = '{8'hAA, 8'hFF, 3'd6, 1'b0, '{8'h55, 0, 0, 0, 0}};
    tab[8]  = '{8'h00, 8'h12, 3'd7, 1'b0, '{8'hFF, 0, 0, 1, 0}};
    tab[9]  = '{8'h7F, 8'h01, 3'd0, 1'b0, '{8'h80, 0, 0, 1, 1}};
    tab[10] = '{8'h05, 8'h05, 3'd1, 1'b1, '{8'h00, 1, 1, 0, 0}};
    tab[11] = '{8'h00, 8'h01, 3'd1, 1'b1, '{8'hFF, 0, 0, 1, 0}};
    tab[12] = '{8'h01, 8'h01, 3'd0, 1'b1, '{8'h03, 0, 0, 0, 0}};
    tab[13] = '{8'h01, 8'h00, 3'd3, 1'b0, '{8'h00, 1, 1, 0, 0}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 1);
    checkOutput("reset_outputs", {out_valid, result, cout, zero, neg, ovf}, 0);

    // Single ADD: latency from the accepting edge to the visible out_valid
    applyStimulus(1, 8'hFF, 8'h01, 3'd0, 0, 0, 1, 1, '{8'h00, 1, 1, 0, 0});
    checkOutput("add_accept", 32'(accepted), 1);
    emitSeen = 0;
    for (int i = 0; i < 10 && !emitSeen; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, '0);
      emitSeen = emitted;
    end
    checkOutput("add_latency", 32'(lastEmitCyc - lastAcceptCyc), 2);

    // Vector table, streamed back to back
    foreach (tab[i]) begin
      applyStimulus(1, tab[i].a, tab[i].b, tab[i].op, tab[i].cin, 0, 1, 1, tab[i].e);
      checkOutput("tab_accept", 32'(accepted), 1);
    end
    drain();

    // Chained accumulator ops; a is garbage when acc_sel=1
    emitCycs.delete();
    applyStimulus(1, 8'h05, 8'h03, 3'd0, 0, 0, 1, 1, '{8'h08, 0, 0, 0, 0});
    applyStimulus(1, 8'hEE, 8'h02, 3'd0, 0, 1, 1, 1, '{8'h0A, 0, 0, 0, 0});
    applyStimulus(1, 8'h33, 8'h0F, 3'd6, 0, 1, 1, 1, '{8'h05, 0, 0, 0, 0});
    drain();
    checkOutput("chain_count", 32'(emitCycs.size()), 3);
    if (emitCycs.size() == 3) begin
      checkOutput("chain_gap0", 32'(emitCycs[1] - emitCycs[0]), 1);
      checkOutput("chain_gap1", 32'(emitCycs[2] - emitCycs[1]), 1);
    end

    // Backpressure: only two beats fit, then a full pipeline drains and refills together
    nAcc = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 8'(i * 16 + 1), 8'h00, 3'd0, 0, 0, 0, 0, '0);
      if (accepted) nAcc++;
    end
    checkOutput("bp_accepts", 32'(nAcc), 2);
    checkOutput("bp_in_ready", 32'(in_ready), 0);
    applyStimulus(1, 8'hC3, 8'h00, 3'd0, 0, 0, 1, 0, '0);
    checkOutput("full_refill_accept", 32'(accepted), 1);
    checkOutput("full_refill_emit", 32'(emitted), 1);
    drain();

    // Reset mid-stream with both stages full
    applyStimulus(1, 8'h11, 8'h22, 3'd0, 0, 0, 0, 0, '0);
    applyStimulus(1, 8'h33, 8'h44, 3'd5, 0, 0, 0, 0, '0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_outputs", {out_valid, result, cout, zero, neg, ovf}, 0);
    sb.delete();
    modelAcc = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midreset_in_ready", 32'(in_ready), 1);
    applyStimulus(1, 8'h55, 8'h00, 3'd0, 0, 1, 1, 1, '{8'h00, 0, 1, 0, 0});
    drain();

    // Random traffic against the model
    nAcc = 0;
    for (int i = 0; i < 20000 && nAcc < 1000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
                    1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0, 0, '0);
      if (accepted) nAcc++;
    end
    checkOutput("random_accepts", 32'(nAcc), 1000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
